// File: rtl/adsr_envelope_if.sv
// Control and level bundle between a voice allocator and its ADSR envelope generator.
// The allocator drives the master side: tick, note events and the four rate and level controls.
// The envelope generator is the slave side: it returns level, activity and phase.
// There is no handshake. note_on and note_off are single-cycle pulses, and tick is a
// single-cycle strobe. The controls are level signals that are sampled on every clock.
// The release control is called release_rate because "release" is a reserved word.
interface adsr_envelope_if #(
    parameter int ENVELOPE_COUNTER_WIDTH = 16,
    parameter int PERCENT_WIDTH          = 7
);
    logic                              tick;
    logic                              note_on;
    logic                              note_off;
    logic [PERCENT_WIDTH-1:0]          attack;
    logic [PERCENT_WIDTH-1:0]          decay;
    logic [PERCENT_WIDTH-1:0]          sustain;
    logic [PERCENT_WIDTH-1:0]          release_rate;
    logic [ENVELOPE_COUNTER_WIDTH-1:0] envelope;
    logic                              active;
    logic [2:0]                        state;

    modport master (
        output tick, note_on, note_off, attack, decay, sustain, release_rate,
        input  envelope, active, state
    );

    modport slave (
        input  tick, note_on, note_off, attack, decay, sustain, release_rate,
        output envelope, active, state
    );
endinterface

// File: rtl/adsr_envelope.sv
// Per-voice ADSR envelope generator.
// note_on and note_off pulses move the voice through its phases:
// ATTACK ramps up, DECAY falls to the sustain level, SUSTAIN holds, RELEASE falls to zero.
// The 16-bit level moves in steps of 256. Each phase has a rate control, and the level takes
// one step every (rate+1) ticks.
module adsr_envelope #(
    parameter int                                ENVELOPE_COUNTER_WIDTH = 16,
    parameter int                                PERCENT_WIDTH          = 7,
    parameter int                                ENVELOPE_PUSH_BITS     = 8,
    parameter logic [ENVELOPE_COUNTER_WIDTH-1:0] ENVELOPE_CEILING       = 16'hffff
) (
    input  logic           clock,
    input  logic           reset,
    adsr_envelope_if.slave bus
);
    localparam int EW = ENVELOPE_COUNTER_WIDTH;
    localparam int PW = PERCENT_WIDTH;

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] ATTACK  = 3'd1;
    localparam logic [2:0] DECAY   = 3'd2;
    localparam logic [2:0] SUSTAIN = 3'd3;
    localparam logic [2:0] RELEASE = 3'd4;

    // One level step. It is one bit wider than the level so that additions and
    // subtractions keep their carry and borrow.
    localparam logic [EW:0] STEP = {{EW{1'b0}}, 1'b1} << ENVELOPE_PUSH_BITS;

    logic [2:0]    state_q, state_d;
    logic [EW-1:0] level_q, level_d;
    logic [EW-1:0] prescale_q, prescale_d;
    logic          active_q, active_d;

    logic [EW-1:0] sustain_level;
    logic [EW-1:0] rate_sel;
    logic          rate_hit;
    logic [EW:0]   up_sum;
    logic [EW:0]   down_diff;

    // Datapath helpers. The sustain control is spread over the full scale by bit replication,
    // so that 0 maps to 0 and the control maximum maps to full scale. The rate compare uses
    // the rate control of the current phase.
    always_comb begin
        sustain_level = {bus.sustain, bus.sustain, bus.sustain[PW-1 -: 2]};
        case (state_q)
            ATTACK:  rate_sel = {{(EW-PW){1'b0}}, bus.attack};
            DECAY:   rate_sel = {{(EW-PW){1'b0}}, bus.decay};
            RELEASE: rate_sel = {{(EW-PW){1'b0}}, bus.release_rate};
            default: rate_sel = '0;
        endcase
        rate_hit  = (prescale_q == rate_sel);
        up_sum    = {1'b0, level_q} + STEP;
        down_diff = {1'b0, level_q} - STEP;
    end

    // Phase register. Reset beats every other input.
    always_ff @(posedge clock) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next phase, level and prescale.
    // Order of precedence: illegal-state recovery, then note_on, then note_off, then tick.
    // An event therefore swallows the level update of a tick that arrives in the same cycle.
    always_comb begin
        state_d    = state_q;
        level_d    = level_q;
        prescale_d = prescale_q;
        if (state_q > RELEASE) begin
            state_d    = IDLE;
            level_d    = '0;
            prescale_d = '0;
        end else if (bus.note_on) begin
            // Legato retrigger: the attack starts from the current level.
            state_d    = ATTACK;
            prescale_d = '0;
        end else if (bus.note_off && (state_q == ATTACK || state_q == DECAY || state_q == SUSTAIN)) begin
            state_d    = RELEASE;
            prescale_d = '0;
        end else if (bus.tick) begin
            case (state_q)
                IDLE:    level_d = '0;
                SUSTAIN: level_d = sustain_level;
                default: begin
                    if (!rate_hit) begin
                        prescale_d = prescale_q + EW'(1);
                    end else begin
                        prescale_d = '0;
                        case (state_q)
                            ATTACK: begin
                                if (up_sum >= {1'b0, ENVELOPE_CEILING}) begin
                                    level_d = ENVELOPE_CEILING;
                                    state_d = DECAY;
                                end else begin
                                    level_d = up_sum[EW-1:0];
                                end
                            end
                            DECAY: begin
                                // A borrow or a landing at or below sustain snaps to sustain.
                                // A level that is already below sustain never ramps upward.
                                if (down_diff[EW] || down_diff[EW-1:0] <= sustain_level) begin
                                    level_d = sustain_level;
                                    state_d = SUSTAIN;
                                end else begin
                                    level_d = down_diff[EW-1:0];
                                end
                            end
                            default: begin
                                // RELEASE: when less than one step remains, finish at zero.
                                if (down_diff[EW]) begin
                                    level_d = '0;
                                    state_d = IDLE;
                                end else begin
                                    level_d = down_diff[EW-1:0];
                                end
                            end
                        endcase
                    end
                end
            endcase
        end
    end

    // Outputs. active is registered from the next phase so that it lines up with state.
    // envelope is the level register with no added delay.
    always_comb begin
        active_d     = (state_d != IDLE);
        bus.envelope = level_q;
        bus.state    = state_q;
        bus.active   = active_q;
    end

    // Level, prescale counter and active flag.
    always_ff @(posedge clock) begin
        if (reset) begin
            level_q    <= '0;
            prescale_q <= '0;
            active_q   <= 1'b0;
        end else begin
            level_q    <= level_d;
            prescale_q <= prescale_d;
            active_q   <= active_d;
        end
    end
endmodule

// File: tb/tb_adsr_envelope.sv
// Directed testbench for adsr_envelope. Each scenario task drives stimulus and checks
// its own results inline against hand-computed values.
module tb_adsr_envelope;
    logic clock = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    // 50 MHz clock.
    always #10 clock = ~clock;

    adsr_envelope_if bus ();

    adsr_envelope dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    // Wait for the next rising edge, then step 1 ns past it to drive and sample.
    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    // One tick strobe, then three quiet clocks: a tick every 4 clocks.
    task automatic tick_once();
        bus.tick = 1'b1;
        cyc();
        bus.tick = 1'b0;
        cyc();
        cyc();
        cyc();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick_once();
    endtask

    task automatic pulse_on();
        bus.note_on = 1'b1;
        cyc();
        bus.note_on = 1'b0;
    endtask

    task automatic pulse_off();
        bus.note_off = 1'b1;
        cyc();
        bus.note_off = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cyc();
        cyc();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        bus.tick = 0; bus.note_on = 0; bus.note_off = 0;
        bus.attack = 0; bus.decay = 0; bus.sustain = 0; bus.release_rate = 0;
        do_reset();
        total++; if (bus.envelope !== 16'h0000) begin bad++; $display("FAIL reset_env got=%h want=0000", bus.envelope); end
        total++; if (bus.state !== 3'd0) begin bad++; $display("FAIL reset_state got=%0d want=0", bus.state); end
        total++; if (bus.active !== 1'b0) begin bad++; $display("FAIL reset_active got=%b want=0", bus.active); end
    endtask

    task automatic test_attack_fast();
        bus.attack = 7'd0;
        pulse_on();
        total++; if (bus.state !== 3'd1 || bus.active !== 1'b1 || bus.envelope !== 16'h0000) begin
            bad++; $display("FAIL atk_start got state=%0d active=%b env=%h want 1/1/0000", bus.state, bus.active, bus.envelope); end
        tick_once();
        total++; if (bus.envelope !== 16'h0100) begin bad++; $display("FAIL atk_tick1 got=%h want=0100", bus.envelope); end
        ticks(254);
        total++; if (bus.envelope !== 16'hff00 || bus.state !== 3'd1) begin
            bad++; $display("FAIL atk_tick255 got env=%h state=%0d want ff00/1", bus.envelope, bus.state); end
        tick_once();
        total++; if (bus.envelope !== 16'hffff || bus.state !== 3'd2) begin
            bad++; $display("FAIL atk_tick256 got env=%h state=%0d want ffff/2", bus.envelope, bus.state); end
    endtask

    task automatic test_attack_slow();
        int n;
        int odd_changes;
        logic [15:0] prev;
        do_reset();
        bus.attack = 7'd1;
        pulse_on();
        n = 0;
        odd_changes = 0;
        prev = bus.envelope;
        while (bus.state !== 3'd2 && n < 600) begin
            tick_once();
            n++;
            if (bus.envelope !== prev && (n % 2) == 1) odd_changes++;
            prev = bus.envelope;
        end
        total++; if (n !== 512) begin bad++; $display("FAIL atk_slow_ticks got=%0d want=512", n); end
        total++; if (odd_changes !== 0) begin bad++; $display("FAIL atk_slow_odd got=%0d want=0", odd_changes); end
        total++; if (bus.envelope !== 16'hffff) begin bad++; $display("FAIL atk_slow_env got=%h want=ffff", bus.envelope); end
    endtask

    task automatic test_decay_sustain();
        int n;
        bus.decay = 7'd0;
        bus.sustain = 7'd64;
        n = 0;
        while (bus.state !== 3'd3 && n < 300) begin
            tick_once();
            n++;
        end
        total++; if (n !== 127) begin bad++; $display("FAIL decay_ticks got=%0d want=127", n); end
        total++; if (bus.envelope !== 16'h8102) begin bad++; $display("FAIL decay_env got=%h want=8102", bus.envelope); end
        bus.sustain = 7'd127;
        tick_once();
        total++; if (bus.envelope !== 16'hffff || bus.state !== 3'd3) begin
            bad++; $display("FAIL sus_track_hi got env=%h state=%0d want ffff/3", bus.envelope, bus.state); end
        bus.sustain = 7'd64;
        tick_once();
        total++; if (bus.envelope !== 16'h8102) begin bad++; $display("FAIL sus_track_back got=%h want=8102", bus.envelope); end
    endtask

    task automatic test_release();
        bus.release_rate = 7'd0;
        pulse_off();
        total++; if (bus.state !== 3'd4 || bus.envelope !== 16'h8102) begin
            bad++; $display("FAIL rel_enter got state=%0d env=%h want 4/8102", bus.state, bus.envelope); end
        ticks(129);
        total++; if (bus.envelope !== 16'h0002 || bus.state !== 3'd4) begin
            bad++; $display("FAIL rel_tick129 got env=%h state=%0d want 0002/4", bus.envelope, bus.state); end
        tick_once();
        total++; if (bus.envelope !== 16'h0000 || bus.state !== 3'd0 || bus.active !== 1'b0) begin
            bad++; $display("FAIL rel_done got env=%h state=%0d active=%b want 0000/0/0", bus.envelope, bus.state, bus.active); end
    endtask

    task automatic test_retrigger();
        bus.attack = 7'd0;
        pulse_on();
        ticks(64);
        total++; if (bus.envelope !== 16'h4000) begin bad++; $display("FAIL retrig_pre got=%h want=4000", bus.envelope); end
        // note_off together with a tick: the event wins and the level stays put.
        bus.note_off = 1'b1;
        bus.tick = 1'b1;
        cyc();
        bus.note_off = 1'b0;
        bus.tick = 1'b0;
        total++; if (bus.state !== 3'd4 || bus.envelope !== 16'h4000) begin
            bad++; $display("FAIL off_with_tick got state=%0d env=%h want 4/4000", bus.state, bus.envelope); end
        pulse_on();
        total++; if (bus.state !== 3'd1 || bus.envelope !== 16'h4000) begin
            bad++; $display("FAIL retrig_legato got state=%0d env=%h want 1/4000", bus.state, bus.envelope); end
        tick_once();
        total++; if (bus.envelope !== 16'h4100) begin bad++; $display("FAIL retrig_step got=%h want=4100", bus.envelope); end
        pulse_off();
        bus.note_on = 1'b1;
        bus.note_off = 1'b1;
        cyc();
        bus.note_on = 1'b0;
        bus.note_off = 1'b0;
        total++; if (bus.state !== 3'd1 || bus.envelope !== 16'h4100) begin
            bad++; $display("FAIL on_off_same got state=%0d env=%h want 1/4100", bus.state, bus.envelope); end
        do_reset();
        pulse_off();
        tick_once();
        total++; if (bus.state !== 3'd0 || bus.envelope !== 16'h0000 || bus.active !== 1'b0) begin
            bad++; $display("FAIL off_in_idle got state=%0d env=%h active=%b want 0/0000/0", bus.state, bus.envelope, bus.active); end
    endtask

    task automatic test_sustain_edges();
        do_reset();
        bus.attack = 7'd0;
        bus.decay = 7'd5;
        bus.sustain = 7'd127;
        pulse_on();
        ticks(256);
        ticks(5);
        total++; if (bus.state !== 3'd2 || bus.envelope !== 16'hffff) begin
            bad++; $display("FAIL decay_wait got state=%0d env=%h want 2/ffff", bus.state, bus.envelope); end
        tick_once();
        total++; if (bus.state !== 3'd3 || bus.envelope !== 16'hffff) begin
            bad++; $display("FAIL decay_snap got state=%0d env=%h want 3/ffff", bus.state, bus.envelope); end
        bus.sustain = 7'd0;
        tick_once();
        total++; if (bus.state !== 3'd3 || bus.envelope !== 16'h0000 || bus.active !== 1'b1) begin
            bad++; $display("FAIL sus_zero got state=%0d env=%h active=%b want 3/0000/1", bus.state, bus.envelope, bus.active); end
    endtask

    task automatic test_reset_mid_attack();
        do_reset();
        bus.attack = 7'd0;
        pulse_on();
        ticks(10);
        total++; if (bus.envelope !== 16'h0a00) begin bad++; $display("FAIL mid_atk_env got=%h want=0a00", bus.envelope); end
        reset = 1'b1;
        bus.tick = 1'b1;
        cyc();
        reset = 1'b0;
        bus.tick = 1'b0;
        total++; if (bus.envelope !== 16'h0000 || bus.state !== 3'd0 || bus.active !== 1'b0) begin
            bad++; $display("FAIL mid_atk_reset got env=%h state=%0d active=%b want 0000/0/0", bus.envelope, bus.state, bus.active); end
    endtask

    initial begin
        reset = 1'b1;
        test_reset();
        test_attack_fast();
        test_attack_slow();
        test_decay_sustain();
        test_release();
        test_retrigger();
        test_sustain_edges();
        test_reset_mid_attack();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
